// File: rtl/tt_um_jimktrains_vslc_sequencer.sv
// Scan-cycle sequencer: loads a byte program into a small store, then on each
// scan tick snapshots the live inputs and streams the program out one
// instruction per clock until the end opcode or the loaded length is reached.
module tt_um_jimktrains_vslc_sequencer #(
   parameter int unsigned PROG_DEPTH = 32,
   parameter logic [7:0]  END_OP     = 8'hFF
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          load_en,
   input  logic                          load_valid,
   input  logic [7:0]                    load_data,
   input  logic                          run,
   input  logic                          scan_tick,
   input  logic [7:0]                    ui_in,
   output logic [7:0]                    instr,
   output logic                          instr_ready,
   output logic [7:0]                    ui_snap,
   output logic [7:0]                    ui_snap_prev,
   output logic [$clog2(PROG_DEPTH)-1:0] pc,
   output logic [$clog2(PROG_DEPTH):0]   prog_len,
   output logic                          busy,
   output logic                          scan_done,
   output logic                          overrun,
   output logic                          load_ovf
);

   localparam int unsigned AW  = $clog2(PROG_DEPTH);
   localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SNAP,
      S_EXEC,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [AW:0] wptr_q, wptr_d;
   logic [AW:0] len_q, len_d;
   // pc carries one extra bit so a full store can end at PROG_DEPTH without
   // wrapping; the port exposes only the addressing bits.
   logic [AW:0] pc_q, pc_d;
   logic [7:0]  instr_q, instr_d;
   logic        rdy_q, rdy_d;
   logic [7:0]  snap_q, snap_d;
   logic [7:0]  prev_q, prev_d;
   logic        done_q, done_d;
   logic        ovr_q, ovr_d;
   logic        lovf_q, lovf_d;

   logic [7:0]  mem [PROG_DEPTH];
   logic        mem_we;
   logic [7:0]  mem_rd;

   assign mem_rd = mem[pc_q[AW-1:0]];

   // Program store write port; contents survive reset by design.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wptr_q[AW-1:0]] <= load_data;
      end
   end

   // Next-state and next-output decode for the sequencer FSM.
   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      len_d   = len_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      rdy_d   = 1'b0;
      snap_d  = snap_q;
      prev_d  = prev_q;
      done_d  = 1'b0;
      lovf_d  = lovf_q;
      mem_we  = 1'b0;
      ovr_d   = ovr_q | (scan_tick & (state_q != S_IDLE));

      unique case (state_q)
         S_IDLE: begin
            if (load_en) begin
               state_d = S_LOAD;
               wptr_d  = '0;
               len_d   = '0;
               lovf_d  = 1'b0;
            end else if (run && scan_tick && (len_q != '0)) begin
               state_d = S_SNAP;
            end
         end
         S_LOAD: begin
            if (!load_en) begin
               len_d   = wptr_q;
               state_d = S_IDLE;
            end else if (load_valid) begin
               if (!wptr_q[AW]) begin
                  mem_we = 1'b1;
                  wptr_d = wptr_q + ONE;
               end else begin
                  lovf_d = 1'b1;
               end
            end
         end
         S_SNAP: begin
            prev_d  = snap_q;
            snap_d  = ui_in;
            pc_d    = '0;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if ((pc_q >= len_q) || (mem_rd == END_OP)) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               instr_d = mem_rd;
               rdy_d   = 1'b1;
               pc_d    = pc_q + ONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         wptr_q  <= '0;
         len_q   <= '0;
         pc_q    <= '0;
         instr_q <= '0;
         rdy_q   <= 1'b0;
         snap_q  <= '0;
         prev_q  <= '0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
         lovf_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         len_q   <= len_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         rdy_q   <= rdy_d;
         snap_q  <= snap_d;
         prev_q  <= prev_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
         lovf_q  <= lovf_d;
      end
   end

   assign instr        = instr_q;
   assign instr_ready  = rdy_q;
   assign ui_snap      = snap_q;
   assign ui_snap_prev = prev_q;
   assign pc           = pc_q[AW-1:0];
   assign prog_len     = len_q;
   assign busy         = (state_q != S_IDLE);
   assign scan_done    = done_q;
   assign overrun      = ovr_q;
   assign load_ovf     = lovf_q;

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_sequencer.sv
// Self-checking bench for the scan-cycle sequencer: table of programs plus
// hand-written sequences for overrun, overflow and reset mid-scan.
`timescale 1ns/1ps
module tb_tt_um_jimktrains_vslc_sequencer;

   localparam int DEPTH = 32;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       load_en = 1'b0;
   logic       load_valid = 1'b0;
   logic [7:0] load_data = 8'h00;
   logic       run = 1'b0;
   logic       scan_tick = 1'b0;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] instr;
   logic       instr_ready;
   logic [7:0] ui_snap;
   logic [7:0] ui_snap_prev;
   logic [4:0] pc;
   logic [5:0] prog_len;
   logic       busy;
   logic       scan_done;
   logic       overrun;
   logic       load_ovf;

   tt_um_jimktrains_vslc_sequencer #(
      .PROG_DEPTH(DEPTH),
      .END_OP    (8'hFF)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_en     (load_en),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .run         (run),
      .scan_tick   (scan_tick),
      .ui_in       (ui_in),
      .instr       (instr),
      .instr_ready (instr_ready),
      .ui_snap     (ui_snap),
      .ui_snap_prev(ui_snap_prev),
      .pc          (pc),
      .prog_len    (prog_len),
      .busy        (busy),
      .scan_done   (scan_done),
      .overrun     (overrun),
      .load_ovf    (load_ovf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_cmp = 0;
   int n_bad = 0;
   int issued = 0;
   int first_issue = -1;
   logic [7:0] exp_q[$];
   logic [7:0] prog_q[$];
   logic [7:0] mon_exp;

   typedef struct {
      int          n;
      logic [63:0] b;
      logic [7:0]  ui;
      int          k;
      int          len;
      int          pcv;
      logic [7:0]  snap;
      logic [7:0]  prev;
      bit          drop_run;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
      end
   endtask

   // Scoreboard consumer: every issued instruction must match the next expected byte.
   always @(negedge clk) begin
      if (instr_ready === 1'b1) begin
         issued++;
         if (first_issue < 0) first_issue = cyc;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL issue_unexpected: got instr=0x%02h, want no issue", instr);
         end else begin
            mon_exp = exp_q.pop_front();
            if (instr !== mon_exp) begin
               n_bad++;
               $display("FAIL issue_instr: got 0x%02h, want 0x%02h", instr, mon_exp);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_prog();
      @(negedge clk);
      load_en = 1'b1;
      @(negedge clk);
      foreach (prog_q[i]) begin
         load_valid = 1'b1;
         load_data  = prog_q[i];
         @(negedge clk);
      end
      load_valid = 1'b0;
      load_en    = 1'b0;
      @(negedge clk);
   endtask

   // Reference model: bytes up to the store depth, stopping at the end opcode.
   task automatic push_expected(input int limit);
      for (int i = 0; i < prog_q.size() && i < limit; i++) begin
         if (prog_q[i] == 8'hFF) break;
         exp_q.push_back(prog_q[i]);
      end
   endtask

   task automatic do_scan(input string tag, input logic [7:0] ui, input int exp_k,
                          input int extra_tick_off, input bit drop_run);
      int c0;
      int done_cyc;
      bit seen;
      push_expected(DEPTH);
      @(negedge clk);
      ui_in = ui;
      run = 1'b1;
      scan_tick = 1'b1;
      c0 = cyc;
      issued = 0;
      first_issue = -1;
      seen = 1'b0;
      done_cyc = -1;
      for (int t = 1; t <= DEPTH + 20 && !seen; t++) begin
         @(negedge clk);
         scan_tick = (extra_tick_off != 0) && (t == extra_tick_off);
         if (drop_run && t == 2) run = 1'b0;
         if (scan_done === 1'b1) begin
            seen = 1'b1;
            done_cyc = cyc;
         end
      end
      scan_tick = 1'b0;
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
      chk({tag, "_done_cycle"}, done_cyc - c0, 3 + exp_k);
      chk({tag, "_issued"}, issued, exp_k);
      if (exp_k > 0) chk({tag, "_first_issue"}, first_issue - c0, 3);
      chk({tag, "_queue_left"}, exp_q.size(), 0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(scan_done), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
      exp_q.delete();
   endtask

   task automatic idle_tick(input string tag, input logic run_v);
      issued = 0;
      @(negedge clk);
      run = run_v;
      scan_tick = 1'b1;
      @(negedge clk);
      scan_tick = 1'b0;
      chk({tag, "_busy0"}, 32'(busy), 32'd0);
      step(3);
      chk({tag, "_busy3"}, 32'(busy), 32'd0);
      chk({tag, "_no_issue"}, issued, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      //           n  bytes                     ui     k  len pc snap   prev   drop_run
      vecs[0] = '{3, 64'h0000_0000_00FF_1000, 8'h05, 2, 3, 2, 8'h05, 8'h00, 1'b0};
      vecs[1] = '{4, 64'h0000_0000_2423_2221, 8'h0A, 4, 4, 4, 8'h0A, 8'h05, 1'b0};
      vecs[2] = '{1, 64'h0000_0000_0000_00FF, 8'h33, 0, 1, 0, 8'h33, 8'h0A, 1'b0};
      vecs[3] = '{5, 64'h0000_0004_03FF_0201, 8'h44, 2, 5, 2, 8'h44, 8'h33, 1'b0};
      vecs[4] = '{2, 64'h0000_0000_0000_7F80, 8'h5A, 2, 2, 2, 8'h5A, 8'h44, 1'b1};

      // Reset values.
      rst_n = 1'b0;
      step(3);
      chk("rst_instr", instr, 0);
      chk("rst_ready", instr_ready, 0);
      chk("rst_snap", ui_snap, 0);
      chk("rst_prev", ui_snap_prev, 0);
      chk("rst_pc", pc, 0);
      chk("rst_len", prog_len, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", scan_done, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_lovf", load_ovf, 0);
      rst_n = 1'b1;

      // Tick with nothing loaded is ignored.
      idle_tick("no_prog", 1'b1);

      // Table of programs: load, scan, check length, snapshots and final pc.
      for (int v = 0; v < 5; v++) begin
         string tag;
         tag = $sformatf("v%0d", v);
         prog_q.delete();
         for (int i = 0; i < vecs[v].n; i++) prog_q.push_back(vecs[v].b[8*i +: 8]);
         load_prog();
         chk({tag, "_len"}, prog_len, vecs[v].len);
         chk({tag, "_lovf"}, load_ovf, 0);
         do_scan(tag, vecs[v].ui, vecs[v].k, 0, vecs[v].drop_run);
         chk({tag, "_snap"}, ui_snap, vecs[v].snap);
         chk({tag, "_prev"}, ui_snap_prev, vecs[v].prev);
         chk({tag, "_pc"}, pc, vecs[v].pcv);
      end

      // run=0 with a program loaded: tick ignored, no overrun.
      idle_tick("run0", 1'b0);
      chk("run0_ovr", overrun, 0);

      // Overrun: second tick during EXEC is dropped, current scan unaffected.
      prog_q.delete();
      for (int i = 0; i < 8; i++) prog_q.push_back(8'h90 + 8'(i));
      load_prog();
      chk("ovr_pre", overrun, 0);
      do_scan("ovr", 8'h11, 8, 3, 1'b0);
      chk("ovr_flag", overrun, 1);
      chk("ovr_instr_hold", instr, 8'h97);
      step(3);
      chk("ovr_no_rescan_busy", busy, 0);
      chk("ovr_no_rescan_issue", issued, 8);

      // Overflow: 33 bytes into a 32-byte store.
      prog_q.delete();
      for (int i = 0; i < 33; i++) prog_q.push_back(8'h40 + 8'(i));
      load_prog();
      chk("ovf_flag", load_ovf, 1);
      chk("ovf_len", prog_len, 32);
      do_scan("ovf", 8'h22, 32, 0, 1'b0);
      chk("ovf_pc_mod_depth", pc, 0);  // pc ends at 32, port shows 32 mod 32

      // Exactly full store: no overflow flag.
      prog_q.delete();
      for (int i = 0; i < 32; i++) prog_q.push_back(8'h40 + 8'(i));
      load_prog();
      chk("full_lovf", load_ovf, 0);
      chk("full_len", prog_len, 32);

      // Reset while EXEC is at pc=2.
      exp_q.push_back(8'h40);
      exp_q.push_back(8'h41);
      @(negedge clk);
      run = 1'b1;
      scan_tick = 1'b1;
      c0 = cyc;
      issued = 0;
      @(negedge clk);
      scan_tick = 1'b0;
      step(3);
      chk("mid_pc_before_rst", pc, 2);
      chk("mid_cycle", cyc - c0, 4);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_busy", busy, 0);
      chk("mid_ready", instr_ready, 0);
      chk("mid_len", prog_len, 0);
      chk("mid_pc", pc, 0);
      chk("mid_instr", instr, 0);
      chk("mid_ovr", overrun, 0);
      chk("mid_issued", issued, 2);
      chk("mid_queue_left", exp_q.size(), 0);
      exp_q.delete();
      idle_tick("post_rst", 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
